// File: rtl/dmem_responder_if.sv
// Load/store bus between the core's MEM stage (master) and dmem_responder (slave).
// The mem_be lane mask exists only when DMEM_BYTE_MASK_EN is defined.
interface dmem_responder_if;
  logic        mem_req;
  logic        mem_rw;
  logic [63:0] mem_addr;
  wire  [63:0] mem_data;
  logic        mem_ready;
  logic        mem_err;
  logic        mem_stall;
`ifdef DMEM_BYTE_MASK_EN
  logic [7:0]  mem_be;
`endif

  modport master (
    output mem_req,
    output mem_rw,
    output mem_addr,
`ifdef DMEM_BYTE_MASK_EN
    output mem_be,
`endif
    inout  mem_data,
    input  mem_ready,
    input  mem_err,
    input  mem_stall
  );

  modport slave (
    input  mem_req,
    input  mem_rw,
    input  mem_addr,
`ifdef DMEM_BYTE_MASK_EN
    input  mem_be,
`endif
    inout  mem_data,
    output mem_ready,
    output mem_err,
    output mem_stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed LATENCY, doubleword array.
// Define DMEM_BYTE_MASK_EN for byte-lane store masking (mem_be) and unaligned addressing.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned HiBit = 3 + IdxW;
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q;
  logic            rw_q;
  logic            err_q;
  logic [63:0]     wdata_q;
  logic [63:0]     rdata_q;
  logic [63:0]     mem_q [DEPTH];

  logic            accept;
  logic            enter_resp;
  logic            wr_en;
  logic            rd_en;
  logic [IdxW-1:0] addr_idx;
  logic            addr_err;
  logic [IdxW-1:0] cur_idx;
  logic            cur_rw;
  logic            cur_err;
  logic [63:0]     cur_wdata;

  assign addr_idx = bus.mem_addr[3 +: IdxW];

`ifdef DMEM_BYTE_MASK_EN
  logic [7:0] be_q;
  logic [7:0] cur_be;
  logic       unused_addr_lsb;
  assign unused_addr_lsb = ^bus.mem_addr[2:0];
  assign addr_err        = |bus.mem_addr[63:HiBit];
`else
  assign addr_err = (|bus.mem_addr[63:HiBit]) | (|bus.mem_addr[2:0]);
`endif

  assign accept = (state_q == StIdle) && bus.mem_req;

  // With LATENCY=1 the array is accessed on the accept edge itself, so use the live bus.
  always_comb begin
    if (state_q == StIdle) begin
      cur_idx   = addr_idx;
      cur_rw    = bus.mem_rw;
      cur_err   = addr_err;
      cur_wdata = bus.mem_data;
    end else begin
      cur_idx   = idx_q;
      cur_rw    = rw_q;
      cur_err   = err_q;
      cur_wdata = wdata_q;
    end
  end

`ifdef DMEM_BYTE_MASK_EN
  assign cur_be = (state_q == StIdle) ? bus.mem_be : be_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_req) begin
          cnt_d = CntLoad;
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Guard on rst so a store landing on the same edge as reset is dropped.
  assign wr_en = enter_resp && cur_rw && !cur_err && !rst;
  assign rd_en = enter_resp && !cur_rw && !cur_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef DMEM_BYTE_MASK_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= addr_idx;
        rw_q    <= bus.mem_rw;
        err_q   <= addr_err;
        wdata_q <= bus.mem_data;
`ifdef DMEM_BYTE_MASK_EN
        be_q    <= bus.mem_be;
`endif
      end
      if (rd_en) begin
        rdata_q <= mem_q[cur_idx];
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
`ifdef DMEM_BYTE_MASK_EN
      for (int i = 0; i < 8; i++) begin
        if (cur_be[i]) begin
          mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
`else
      mem_q[cur_idx] <= cur_wdata;
`endif
    end
  end

  assign bus.mem_ready = (state_q == StResp);
  assign bus.mem_err   = (state_q == StResp) && err_q;
  assign bus.mem_stall = ((state_q == StIdle) && bus.mem_req) || (state_q == StWait);
  assign bus.mem_data  = ((state_q == StResp) && !rw_q && !err_q) ? rdata_q : 'z;

endmodule
